npc_ctrl: RTL and testbench

- Sequential fetch and next-PC controller for the multi-cycle CPU.
- Drives the PC register's write port (data_in/pcsrc equivalents) and fetches the instruction at the current PC from instruction memory using a req/ack handshake.
- Collects redirect information from the execute stage and commits exactly one PC update per instruction.
- Sits between the PC register, instruction memory and the control unit.

---
 rtl/npc_ctrl_if.sv | 36 +++
 rtl/npc_ctrl.sv | 117 +++++++++++
 tb/tb_npc_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/npc_ctrl_if.sv
// rtl/npc_ctrl_if.sv - fetch bus, execute redirect and PC write signals of npc_ctrl
interface npc_ctrl_if;
    logic [31:0] pc;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        br_taken;
    logic [15:0] br_off;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        stall;
    logic [31:0] npc;
    logic        pc_we;
    logic        addr_err;

    modport master (
        input  pc, if_ack, if_rdata, ex_done, br_taken, br_off, jmp, jmp_idx,
               jr, jr_target, exc, eret, epc, stall,
        output if_req, if_addr, instr, instr_valid, npc, pc_we, addr_err
    );

    modport slave (
        output pc, if_ack, if_rdata, ex_done, br_taken, br_off, jmp, jmp_idx,
               jr, jr_target, exc, eret, epc, stall,
        input  if_req, if_addr, instr, instr_valid, npc, pc_we, addr_err
    );
endinterface

// File: rtl/npc_ctrl.sv
// rtl/npc_ctrl.sv - fetch and next-PC commit controller for the multi-cycle CPU
module npc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic       clk,
    input  logic       rst,
    npc_ctrl_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT_EX, COMMIT} state_t;

    state_t      state_q, state_d;
    logic        if_req_q, if_req_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] npc_q, npc_d;
    logic        addr_err_q, addr_err_d;
    logic        pc_we;

    logic [31:0] seq;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] target;

    always_comb begin
        seq        = bus.pc + 32'd4;
        br_target  = seq + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};
        jmp_target = {seq[31:28], bus.jmp_idx, 2'b00};
        if (bus.exc) begin
            target = EXC_VECTOR;
        end else if (bus.eret) begin
            target = bus.epc;
        end else if (bus.jr) begin
            target = bus.jr_target;
        end else if (bus.jmp) begin
            target = jmp_target;
        end else if (bus.br_taken) begin
            target = br_target;
        end else begin
            target = seq;
        end
    end

    always_comb begin
        state_d       = state_q;
        if_req_d      = if_req_q;
        if_addr_d     = if_addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        npc_d         = npc_q;
        addr_err_d    = 1'b0;
        pc_we         = 1'b0;
        case (state_q)
            FETCH: begin
                // The request is raised one cycle into FETCH so pc has already taken the committed value.
                if (!if_req_q) begin
                    if_req_d  = 1'b1;
                    if_addr_d = bus.pc;
                end else if (bus.if_ack) begin
                    instr_d       = bus.if_rdata;
                    instr_valid_d = 1'b1;
                    if_req_d      = 1'b0;
                    state_d       = WAIT_EX;
                end
            end
            WAIT_EX: begin
                if (bus.ex_done) begin
                    state_d = COMMIT;
                    if (!bus.exc && (target[1:0] != 2'b00)) begin
                        npc_d      = EXC_VECTOR;
                        addr_err_d = 1'b1;
                    end else begin
                        npc_d = target;
                    end
                end
            end
            COMMIT: begin
                if (!bus.stall && !rst) begin
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            if_req_q      <= 1'b0;
            if_addr_q     <= 32'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            npc_q         <= RESET_PC;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_req_q      <= if_req_d;
            if_addr_q     <= if_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            npc_q         <= npc_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign bus.if_req      = if_req_q;
    assign bus.if_addr     = if_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.npc         = npc_q;
    assign bus.pc_we       = pc_we;
    assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_npc_ctrl.sv
// tb/tb_npc_ctrl.sv - self-checking bench for npc_ctrl
module tb_npc_ctrl;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npc_ctrl_if bus();
    npc_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // PC register that the controller writes.
    logic [31:0] tb_pc;
    always @(posedge clk) begin
        if (rst)            tb_pc <= RESET_PC;
        else if (bus.pc_we) tb_pc <= bus.npc;
    end
    assign bus.pc = tb_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_iv     = 0;
    int n_we     = 0;
    int n_err    = 0;
    logic [31:0] exp_instr = 32'd0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Next PC from the redirect rules, in plain integer arithmetic; bit 32 = address error.
    function automatic logic [32:0] model(input logic [31:0] pc_v, input logic e, input logic er,
                                          input logic j, input logic jm, input logic br,
                                          input logic [31:0] epc_v, input logic [31:0] jrt,
                                          input logic [25:0] idx, input logic [15:0] off);
        longint m32, seq, t;
        m32 = 64'sh1_0000_0000;
        seq = (longint'(pc_v) + 4) % m32;
        if (e) return {1'b0, EXC_VECTOR};
        if (er)      t = longint'(epc_v);
        else if (j)  t = longint'(jrt);
        else if (jm) t = (seq / 268435456) * 268435456 + longint'(idx) * 4;
        else if (br) t = (seq + 4 * longint'($signed(off)) + m32) % m32;
        else         t = seq;
        if (t % 4 != 0) return {1'b1, EXC_VECTOR};
        return {1'b0, t[31:0]};
    endfunction

    initial begin : compare
        logic req_prev, ack_prev, we_prev;
        logic [32:0] e;
        req_prev = 1'b0; ack_prev = 1'b0; we_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.if_req) check("if_addr_eq_pc", bus.if_addr, tb_pc);
                if (req_prev && !ack_prev) check("if_req_hold", bus.if_req, 1);
                if (bus.instr_valid) begin
                    n_iv++;
                    check("instr", bus.instr, exp_instr);
                end
                if (bus.addr_err) begin
                    n_err++;
                    check("addr_err_npc", bus.npc, EXC_VECTOR);
                end
                if (bus.pc_we) begin
                    n_we++;
                    check("pc_we_back_to_back", we_prev, 0);
                    check("pc_we_during_stall", bus.stall, 0);
                    if (exp_q.size() == 0) check("pc_we_unexpected", bus.pc_we, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("npc", bus.npc, e[31:0]);
                    end
                end
                req_prev = bus.if_req;
                ack_prev = bus.if_ack;
                we_prev  = bus.pc_we;
            end else begin
                req_prev = 1'b0; ack_prev = 1'b0; we_prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.if_ack = 0; bus.if_rdata = 0; bus.ex_done = 0; bus.br_taken = 0; bus.br_off = 0;
        bus.jmp = 0; bus.jmp_idx = 0; bus.jr = 0; bus.jr_target = 0; bus.exc = 0;
        bus.eret = 0; bus.epc = 0; bus.stall = 0;
    endtask

    task automatic wait_req();
        int waited;
        waited = 0;
        while (!bus.if_req && waited < 20) begin
            step();
            waited++;
        end
        check("fetch_req_seen", bus.if_req, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_if_req"}, bus.if_req, 0);
        check({tag, "_if_addr"}, bus.if_addr, 0);
        check({tag, "_instr"}, bus.instr, 0);
        check({tag, "_instr_valid"}, bus.instr_valid, 0);
        check({tag, "_npc"}, bus.npc, RESET_PC);
        check({tag, "_pc_we"}, bus.pc_we, 0);
        check({tag, "_addr_err"}, bus.addr_err, 0);
    endtask

    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] rdata,
                             input int ack_dly, input int stall_n,
                             input logic e, input logic er, input logic j, input logic jm, input logic br,
                             input logic [31:0] epc_v, input logic [31:0] jrt,
                             input logic [25:0] idx, input logic [15:0] off,
                             input logic [31:0] lit_npc, input logic lit_err);
        logic [32:0] m;
        n_iv = 0; n_we = 0; n_err = 0;
        wait_req();
        check("fetch_addr", bus.if_addr, exp_pc);
        // Slow memory; execute-side strobes during FETCH must be ignored.
        for (int k = 0; k < ack_dly; k++) begin
            bus.ex_done = 1; bus.exc = 1; bus.jr = 1; bus.jr_target = 32'h0000_0002;
            step();
        end
        clear_in();
        bus.if_ack = 1; bus.if_rdata = rdata; exp_instr = rdata;
        step();
        bus.if_rdata = ~rdata;
        step();
        bus.if_ack = 0; bus.ex_done = 1;
        bus.exc = e; bus.eret = er; bus.jr = j; bus.jmp = jm; bus.br_taken = br;
        bus.epc = epc_v; bus.jr_target = jrt; bus.jmp_idx = idx; bus.br_off = off;
        m = model(bus.pc, e, er, j, jm, br, epc_v, jrt, idx, off);
        check("model_pin", m, {lit_err, lit_npc});
        exp_q.push_back(m);
        step();
        clear_in();
        bus.stall = (stall_n > 0);
        for (int k = 0; k < stall_n; k++) step();
        bus.stall = 0;
        step();
        check("instr_valid_pulses", n_iv, 1);
        check("pc_we_pulses", n_we, 1);
        check("addr_err_pulses", n_err, m[32]);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        clear_in();
        rst = 1;
        repeat (3) step();
        check_reset_vals("reset");
        rst = 0;
        step();
        check("first_if_req", bus.if_req, 1);
        check("first_if_addr", bus.if_addr, RESET_PC);

        //         pc            rdata        dly stl e  er j  jm br epc            jr_target      idx           off       npc            err
        run_instr(32'h0040_0000, 32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         26'h0,        16'h0,    32'h0040_0004, 0);
        run_instr(32'h0040_0004, 32'h1111_0001, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0040_0010, 26'h0,        16'h0,    32'h0040_0010, 0);
        run_instr(32'h0040_0010, 32'h1111_0002, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         26'h0,        16'hFFFC, 32'h0040_0004, 0);
        run_instr(32'h0040_0004, 32'h1111_0003, 1, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0040_0010, 26'h0,        16'h0,    32'h0040_0010, 0);
        run_instr(32'h0040_0010, 32'h1111_0004, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         26'h0,        16'h0003, 32'h0040_0020, 0);
        run_instr(32'h0040_0020, 32'h1111_0005, 5, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0040_0000, 26'h0,        16'h0,    32'h0040_0000, 0);
        run_instr(32'h0040_0000, 32'h1111_0006, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         26'h010_0008, 16'h0,    32'h0040_0020, 0);
        run_instr(32'h0040_0020, 32'h1111_0007, 0, 0, 0, 0, 1, 1, 0, 32'h0,        32'h0040_0100, 26'h010_0008, 16'h0,    32'h0040_0100, 0);
        run_instr(32'h0040_0100, 32'h1111_0008, 0, 4, 1, 1, 1, 0, 0, 32'h0040_0200, 32'h0040_0300, 26'h0,       16'h0,    32'h0040_0004, 0);
        run_instr(32'h0040_0004, 32'h1111_0009, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0040_0102, 26'h0,        16'h0,    32'h0040_0004, 1);
        run_instr(32'h0040_0004, 32'h1111_000A, 2, 1, 0, 1, 0, 0, 1, 32'h0040_0050, 32'h0,        26'h0,        16'h7FFF, 32'h0040_0050, 0);
        run_instr(32'h0040_0050, 32'h1111_000B, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         26'h0,        16'h8000, 32'h003E_0054, 0);
        run_instr(32'h003E_0054, 32'h1111_000C, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'hFFFF_FFFC, 26'h0,        16'h0,    32'hFFFF_FFFC, 0);
        run_instr(32'hFFFF_FFFC, 32'h1111_000D, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         26'h0,        16'h0,    32'h0000_0000, 0);
        run_instr(32'h0000_0000, 32'h1111_000E, 0, 2, 0, 0, 0, 1, 0, 32'h0,        32'h0,         26'h3FF_FFFF, 16'h0,    32'h0FFF_FFFC, 0);

        // Reset while waiting for execute, with a commit-worthy ex_done in the same cycle.
        wait_req();
        bus.if_ack = 1; bus.if_rdata = 32'h2222_0001; exp_instr = 32'h2222_0001;
        step();
        clear_in();
        rst = 1; bus.ex_done = 1; bus.jr = 1; bus.jr_target = 32'h0040_1234;
        step();
        check_reset_vals("midrst");
        rst = 0;
        clear_in();
        bus.if_ack = 1; bus.if_rdata = 32'hDEAD_BEEF;
        step();
        check("late_ack_instr_valid", bus.instr_valid, 0);
        check("late_ack_instr", bus.instr, 0);
        check("post_rst_if_req", bus.if_req, 1);
        check("post_rst_if_addr", bus.if_addr, RESET_PC);
        bus.if_ack = 0;
        run_instr(32'h0040_0000, 32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 16'h0, 32'h0040_0004, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
